// File: rtl/mib_issue_queue.sv
// mib_issue_queue: buffers upstream move/immediate instructions in a small
// FIFO and issues them one at a time to the MIB through a registered
// output stage that supports back-to-back issue with no bubble.
module mib_issue_queue #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_imm,
    input  logic [ADDR_WIDTH-1:0] in_src,
    input  logic [ADDR_WIDTH-1:0] in_dst,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  move_valid,
    input  logic                  move_ack,
    output logic [ADDR_WIDTH-1:0] move_from,
    output logic [ADDR_WIDTH-1:0] move_to,
    output logic                  immediate_valid,
    input  logic                  immediate_ack,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic [ADDR_WIDTH-1:0] immediate_addr,
    output logic                  idle,
    output logic [15:0]           issued_count
);

    // Pointer width relies on DEPTH being a power of two so that the
    // natural binary overflow of the pointers gives the modulo-DEPTH wrap.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_MOVE = 2'd1,
        ISSUE_IMM  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic                  mem_is_imm [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_src    [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_dst    [DEPTH];
    logic [DATA_WIDTH-1:0] mem_imm    [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] occupancy;

    logic fifo_empty;
    logic push;
    logic complete;
    logic pop;
    logic head_is_imm;

    // in_ready comes only from the registered occupancy, so the acks never
    // reach it combinationally; a pop on a full edge cannot be reused for a
    // push on that same edge.
    assign fifo_empty  = (occupancy == '0);
    assign in_ready    = (occupancy < CNT_W'(DEPTH));
    assign push        = in_valid && in_ready;
    assign complete    = ((state == ISSUE_MOVE) && move_ack) ||
                         ((state == ISSUE_IMM)  && immediate_ack);
    assign pop         = !fifo_empty && ((state == IDLE) || complete);
    assign head_is_imm = mem_is_imm[head];

    // State register; reset drops any outstanding instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: load from the FIFO whenever the output stage is
    // free (idle or completing this edge), choosing the issue kind by the
    // head entry.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = head_is_imm ? ISSUE_IMM : ISSUE_MOVE;
                end
            end
            ISSUE_MOVE, ISSUE_IMM: begin
                if (complete) begin
                    if (fifo_empty) begin
                        next_state = IDLE;
                    end else begin
                        next_state = head_is_imm ? ISSUE_IMM : ISSUE_MOVE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: valids follow the registered state directly.
    always_comb begin
        move_valid      = (state == ISSUE_MOVE);
        immediate_valid = (state == ISSUE_IMM);
        idle            = (state == IDLE) && fifo_empty;
    end

    // FIFO storage write; contents need no reset because occupancy guards them.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_is_imm[tail] <= in_is_imm;
            mem_src[tail]    <= in_src;
            mem_dst[tail]    <= in_dst;
            mem_imm[tail]    <= in_imm;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Payload registers: only the fields of the popped kind are loaded, so
    // everything else keeps its last value while not being issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            move_from      <= '0;
            move_to        <= '0;
            immediate      <= '0;
            immediate_addr <= '0;
        end else if (pop) begin
            if (head_is_imm) begin
                immediate_addr <= mem_dst[head];
                immediate      <= mem_imm[head];
            end else begin
                move_from <= mem_src[head];
                move_to   <= mem_dst[head];
            end
        end
    end

    // Completed-transfer counter, free-running with natural 16-bit wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            issued_count <= '0;
        end else if (complete) begin
            issued_count <= issued_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mib_issue_queue.sv
// tb_mib_issue_queue: directed scenarios plus randomized traffic, all
// compared against a queue-based behavioural model of the issue queue.
module tb_mib_issue_queue;

    localparam int AW    = 4;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic          in_is_imm;
    logic [AW-1:0] in_src;
    logic [AW-1:0] in_dst;
    logic [DW-1:0] in_imm;
    logic          move_valid;
    logic          move_ack;
    logic [AW-1:0] move_from;
    logic [AW-1:0] move_to;
    logic          immediate_valid;
    logic          immediate_ack;
    logic [DW-1:0] immediate;
    logic [AW-1:0] immediate_addr;
    logic          idle;
    logic [15:0]   issued_count;

    mib_issue_queue #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_is_imm(in_is_imm),
        .in_src(in_src),
        .in_dst(in_dst),
        .in_imm(in_imm),
        .move_valid(move_valid),
        .move_ack(move_ack),
        .move_from(move_from),
        .move_to(move_to),
        .immediate_valid(immediate_valid),
        .immediate_ack(immediate_ack),
        .immediate(immediate),
        .immediate_addr(immediate_addr),
        .idle(idle),
        .issued_count(issued_count)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit            isImm;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] imm;
    } entry_t;

    // Reference model: a plain queue of waiting instructions plus the one
    // instruction currently offered to the MIB.
    entry_t        modelQ[$];
    bit            haveCur;
    entry_t        cur;
    logic [AW-1:0] expFrom;
    logic [AW-1:0] expTo;
    logic [DW-1:0] expImm;
    logic [AW-1:0] expAddr;
    logic [15:0]   expCount;
    int            completions;

    int total;
    int bad;

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelStep(input bit rst, input bit v, input entry_t e,
                             input bit mack, input bit iack);
        int  sizeBefore;
        bit  doPush;
        bit  done;
        if (rst) begin
            modelQ.delete();
            haveCur     = 0;
            expFrom     = '0;
            expTo       = '0;
            expImm      = '0;
            expAddr     = '0;
            expCount    = '0;
            completions = 0;
        end else begin
            sizeBefore = modelQ.size();
            doPush     = v && (sizeBefore < DEPTH);
            done       = haveCur && (cur.isImm ? iack : mack);
            if (done) begin
                expCount++;
                completions++;
            end
            if (!haveCur || done) begin
                if (sizeBefore > 0) begin
                    cur     = modelQ.pop_front();
                    haveCur = 1;
                    if (cur.isImm) begin
                        expAddr = cur.dst;
                        expImm  = cur.imm;
                    end else begin
                        expFrom = cur.src;
                        expTo   = cur.dst;
                    end
                end else begin
                    haveCur = 0;
                end
            end
            if (doPush) begin
                modelQ.push_back(e);
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkAll();
        checkOutput("in_ready", in_ready, modelQ.size() < DEPTH);
        checkOutput("move_valid", move_valid, haveCur && !cur.isImm);
        checkOutput("immediate_valid", immediate_valid, haveCur && cur.isImm);
        checkOutput("idle", idle, !haveCur && modelQ.size() == 0);
        checkOutput("issued_count", issued_count, expCount);
        checkOutput("move_from", move_from, expFrom);
        checkOutput("move_to", move_to, expTo);
        checkOutput("immediate", immediate, expImm);
        checkOutput("immediate_addr", immediate_addr, expAddr);
    endtask

    // Drive one cycle of inputs, clock it, update the model, check outputs.
    task automatic applyStimulus(input bit rst, input bit v, input bit isImm,
                                 input logic [AW-1:0] src, input logic [AW-1:0] dst,
                                 input logic [DW-1:0] imm, input bit mack,
                                 input bit iack);
        entry_t e;
        e.isImm = isImm;
        e.src   = src;
        e.dst   = dst;
        e.imm   = imm;
        reset         = rst;
        in_valid      = v;
        in_is_imm     = isImm;
        in_src        = src;
        in_dst        = dst;
        in_imm        = imm;
        move_ack      = mack;
        immediate_ack = iack;
        @(posedge clock);
        modelStep(rst, v, e, mack, iack);
        #1;
        checkAll();
    endtask

    task automatic idleCycle(input bit mack, input bit iack);
        applyStimulus(0, 0, 0, '0, '0, '0, mack, iack);
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, '0, '0, '0, 0, 0);
        applyStimulus(1, 1, 1, 4'hF, 4'hF, '1, 1, 1);
        applyStimulus(0, 0, 0, '0, '0, '0, 0, 0);
    endtask

    // Scenario sequence.
    initial begin
        total       = 0;
        bad         = 0;
        haveCur     = 0;
        expCount    = '0;
        completions = 0;
        reset = 1'b1; in_valid = 0; in_is_imm = 0; in_src = '0; in_dst = '0;
        in_imm = '0; move_ack = 0; immediate_ack = 0;

        doReset();
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_idle", idle, 1);
        checkOutput("rst_move_valid", move_valid, 0);
        checkOutput("rst_imm_valid", immediate_valid, 0);

        // Single move with a held-off ack.
        applyStimulus(0, 1, 0, 4'd3, 4'd7, '0, 0, 0);
        checkOutput("single_not_yet", move_valid, 0);
        idleCycle(0, 0);
        checkOutput("single_valid_c2", move_valid, 1);
        checkOutput("single_from", move_from, 3);
        checkOutput("single_to", move_to, 7);
        for (int i = 0; i < 5; i++) begin
            idleCycle(0, 0);
            checkOutput("single_hold_valid", move_valid, 1);
            checkOutput("single_hold_from", move_from, 3);
            checkOutput("single_hold_to", move_to, 7);
        end
        idleCycle(1, 0);
        checkOutput("single_drop", move_valid, 0);
        checkOutput("single_count", issued_count, 1);
        checkOutput("single_idle", idle, 1);

        // Mixed back-to-back with acks tied high.
        doReset();
        applyStimulus(0, 1, 1, 4'd0, 4'd5, 64'hDEADBEEF_00000001, 1, 1);
        applyStimulus(0, 1, 0, 4'd1, 4'd2, '0, 1, 1);
        checkOutput("b2b_imm_valid", immediate_valid, 1);
        checkOutput("b2b_imm_value", immediate, 64'hDEADBEEF_00000001);
        checkOutput("b2b_imm_addr", immediate_addr, 5);
        idleCycle(1, 1);
        checkOutput("b2b_imm_gone", immediate_valid, 0);
        checkOutput("b2b_move_valid", move_valid, 1);
        checkOutput("b2b_move_from", move_from, 1);
        checkOutput("b2b_move_to", move_to, 2);
        idleCycle(1, 1);
        checkOutput("b2b_move_gone", move_valid, 0);
        checkOutput("b2b_count", issued_count, 2);

        // Fill to full, try one more push, then drain in order.
        doReset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(0, 1, i[0], 4'(i + 1), 4'(i + 8), 64'(i * 17 + 3), 0, 0);
        end
        checkOutput("full_in_ready", in_ready, 0);
        applyStimulus(0, 1, 1, 4'hA, 4'hB, 64'hBAD, 0, 0);
        checkOutput("full_stays", in_ready, 0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            idleCycle(1, 1);
        end
        checkOutput("full_drained_count", issued_count, DEPTH + 1);
        checkOutput("full_drained_idle", idle, 1);

        // Stray acks of the wrong kind, and while idle.
        doReset();
        applyStimulus(0, 1, 0, 4'd4, 4'd6, '0, 0, 0);
        idleCycle(0, 0);
        idleCycle(0, 1);
        checkOutput("stray_still_valid", move_valid, 1);
        checkOutput("stray_count0", issued_count, 0);
        idleCycle(1, 0);
        idleCycle(1, 1);
        checkOutput("stray_idle_count", issued_count, 1);
        checkOutput("stray_idle", idle, 1);

        // Reset while a move is offered with two entries waiting.
        doReset();
        applyStimulus(0, 1, 0, 4'd1, 4'd1, '0, 0, 0);
        applyStimulus(0, 1, 0, 4'd2, 4'd2, '0, 0, 0);
        applyStimulus(0, 1, 1, 4'd3, 4'd3, 64'h55, 0, 0);
        checkOutput("midrst_pre_valid", move_valid, 1);
        applyStimulus(1, 0, 0, '0, '0, '0, 1, 1);
        checkOutput("midrst_move_valid", move_valid, 0);
        checkOutput("midrst_imm_valid", immediate_valid, 0);
        checkOutput("midrst_idle", idle, 1);
        checkOutput("midrst_count", issued_count, 0);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1, 1);
            checkOutput("midrst_no_stale", move_valid | immediate_valid, 0);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                          $urandom_range(0, 1), 4'($urandom), 4'($urandom),
                          {$urandom, $urandom}, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 2) != 0));
        end

        // Counter wrap after 65536 completions of continuous traffic.
        doReset();
        for (int i = 0; i < 70000 && completions < 65536; i++) begin
            applyStimulus(0, 1, $urandom_range(0, 1), 4'($urandom), 4'($urandom),
                          {$urandom, $urandom}, 1, 1);
        end
        checkOutput("wrap_reached", 64'(completions), 64'd65536);
        checkOutput("wrap_zero", issued_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
